// File: rtl/rx_word_assembler.sv
// Packs UART receiver bytes little-endian into 32-bit words and queues them in a FWFT FIFO.
// Optional partial-word timeout enabled by defining RX_WORD_TIMEOUT_EN.
module rx_word_assembler #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     res_n,
    input  logic [7:0]               in_byte,
    input  logic                     in_rdy,
    output logic [31:0]              out_word,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [1:0]               byte_idx,
    output logic                     overflow,
    output logic                     frame_err,
    input  logic                     clr_status
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 2) begin : g_param_check
        $error("rx_word_assembler: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 2");
    end

    typedef enum logic {
        IDLE,
        COLLECT
    } asm_state_t;

    asm_state_t        state;
    logic [23:0]       partial;
    logic [31:0]       mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              word_done;
    logic              pop;
    logic              push_ok;
    logic              timeout_hit;
    logic [31:0]       full_word;

    assign word_done = in_rdy && state == COLLECT && byte_idx == 2'd3;
    assign full_word = {in_byte, partial};
    assign out_valid = level != '0;
    assign pop       = out_valid && out_ready;
    // A pop on the same edge frees the slot the new word needs, so a full FIFO still accepts.
    assign push_ok   = word_done && (level != FULL_LVL || pop);
    assign out_word  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state    <= IDLE;
            byte_idx <= 2'd0;
            partial  <= '0;
        end else if (in_rdy) begin
            case (byte_idx)
                2'd0:    partial[7:0]   <= in_byte;
                2'd1:    partial[15:8]  <= in_byte;
                2'd2:    partial[23:16] <= in_byte;
                default: partial        <= '0;
            endcase
            byte_idx <= byte_idx + 2'd1;
            state    <= (byte_idx == 2'd3) ? IDLE : COLLECT;
        end else if (timeout_hit) begin
            state    <= IDLE;
            byte_idx <= 2'd0;
            partial  <= '0;
        end
    end

`ifdef RX_WORD_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] idle_cnt;

    // A byte arriving on the expiry cycle wins over the timeout.
    assign timeout_hit = state == COLLECT && !in_rdy && idle_cnt == CNT_LAST;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            idle_cnt  <= '0;
            frame_err <= 1'b0;
        end else begin
            if (in_rdy || state == IDLE || timeout_hit) idle_cnt <= '0;
            else                                         idle_cnt <= idle_cnt + CNT_W'(1);
            if (timeout_hit)     frame_err <= 1'b1;
            else if (clr_status) frame_err <= 1'b0;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign frame_err   = 1'b0;
`endif

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
            if (word_done && !push_ok) overflow <= 1'b1;
            else if (clr_status)       overflow <= 1'b0;
        end
    end

    // NOTE: storage has no reset; stale entries are never visible because out_word is
    // masked by out_valid, and leaving them unreset lets the array map to plain RAM.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= full_word;
    end

endmodule

// File: tb/tb_rx_word_assembler.sv
// Self-checking bench for rx_word_assembler: randomized byte streams against a queue-based
// reference model, plus directed boundary scenarios.
module tb_rx_word_assembler;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;
    localparam int LVL_W   = $clog2(DEPTH) + 1;
    localparam int VW      = 1 + 32 + LVL_W + 2 + 1 + 1;
`ifdef RX_WORD_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             res_n = 1'b0;
    logic [7:0]       in_byte = 8'h00;
    logic             in_rdy = 1'b0;
    logic [31:0]      out_word;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [LVL_W-1:0] level;
    logic [1:0]       byte_idx;
    logic             overflow;
    logic             frame_err;
    logic             clr_status = 1'b0;

    int checks   = 0;
    int failures = 0;

    rx_word_assembler #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .res_n      (res_n),
        .in_byte    (in_byte),
        .in_rdy     (in_rdy),
        .out_word   (out_word),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .level      (level),
        .byte_idx   (byte_idx),
        .overflow   (overflow),
        .frame_err  (frame_err),
        .clr_status (clr_status)
    );

    always #5 clk = ~clk;

    logic [VW-1:0] dut_vec;
    assign dut_vec = {out_valid, out_word, level, byte_idx, overflow, frame_err};

    // Reference model: a word queue, a byte queue for the partial word, and sticky flags.
    logic [31:0] mq[$];
    logic [7:0]  mparts[$];
    int          midle;
    bit          movf;
    bit          mferr;

    function automatic void model_clear();
        mq.delete();
        mparts.delete();
        midle = 0;
        movf  = 1'b0;
        mferr = 1'b0;
    endfunction

    function automatic logic [VW-1:0] model_vec();
        logic [31:0] head;
        head = (mq.size() != 0) ? mq[0] : 32'h0;
        return {mq.size() != 0, head, LVL_W'(mq.size()), 2'(mparts.size()), movf, mferr};
    endfunction

    function automatic void model_step(input logic rdy, input logic [7:0] b,
                                       input logic ordy, input logic clr);
        int          pre_size;
        bit          pop_now;
        bit          have_word;
        bit          ovf_set;
        bit          fe_set;
        logic [31:0] w;
        pre_size  = mq.size();
        pop_now   = (pre_size != 0) && ordy;
        have_word = 1'b0;
        ovf_set   = 1'b0;
        fe_set    = 1'b0;
        w         = 32'h0;
        if (rdy) begin
            mparts.push_back(b);
            midle = 0;
            if (mparts.size() == 4) begin
                w = {mparts[3], mparts[2], mparts[1], mparts[0]};
                have_word = 1'b1;
                mparts.delete();
            end
        end else if (mparts.size() != 0) begin
            midle++;
            if (TO_EN && midle == TIMEOUT) begin
                mparts.delete();
                midle  = 0;
                fe_set = 1'b1;
            end
        end
        if (pop_now) void'(mq.pop_front());
        if (have_word) begin
            if (pre_size < DEPTH || pop_now) mq.push_back(w);
            else ovf_set = 1'b1;
        end
        if (ovf_set)  movf = 1'b1;
        else if (clr) movf = 1'b0;
        if (fe_set)   mferr = 1'b1;
        else if (clr) mferr = 1'b0;
    endfunction

    // One clock: drive inputs just after an edge, advance the model, sample 1 ns after the next edge.
    task automatic cycle(input logic rdy, input logic [7:0] b, input logic ordy, input logic clr);
        in_rdy     = rdy;
        in_byte    = b;
        out_ready  = ordy;
        clr_status = clr;
        model_step(rdy, b, ordy, clr);
        @(posedge clk);
        #1;
        in_rdy     = 1'b0;
        out_ready  = 1'b0;
        clr_status = 1'b0;
    endtask

    task automatic do_reset();
        res_n      = 1'b0;
        in_rdy     = 1'b0;
        out_ready  = 1'b0;
        clr_status = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        res_n = 1'b1;
    endtask

    task automatic test_reset();
        res_n = 1'b0;
        #3;
        checks++;
        if (dut_vec !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected all zero", dut_vec);
        end
        model_clear();
        @(posedge clk);
        #1;
        res_n = 1'b1;
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if (dut_vec !== model_vec()) begin
            failures++;
            $display("FAIL reset_idle: got %h expected %h", dut_vec, model_vec());
        end
    endtask

    task automatic test_basic();
        do_reset();
        cycle(1'b1, 8'h11, 1'b0, 1'b0);
        cycle(1'b1, 8'h22, 1'b0, 1'b0);
        cycle(1'b1, 8'h33, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || byte_idx !== 2'd3) begin
            failures++;
            $display("FAIL basic_three_bytes: valid=%b idx=%0d expected valid=0 idx=3", out_valid, byte_idx);
        end
        cycle(1'b1, 8'h44, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_word !== 32'h44332211 || level !== LVL_W'(1) || byte_idx !== 2'd0) begin
            failures++;
            $display("FAIL basic_word: valid=%b word=%h level=%0d idx=%0d expected 1 44332211 1 0",
                     out_valid, out_word, level, byte_idx);
        end
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || out_word !== 32'h0 || level !== '0) begin
            failures++;
            $display("FAIL basic_pop: valid=%b word=%h level=%0d expected 0 0 0", out_valid, out_word, level);
        end
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if (dut_vec !== model_vec()) begin
            failures++;
            $display("FAIL basic_ready_when_empty: got %h expected %h", dut_vec, model_vec());
        end
        for (int i = 0; i < 24; i++) begin
            cycle(1'($urandom_range(0, 2) != 0), 8'($urandom), 1'($urandom_range(0, 3) == 0), 1'b0);
            checks++;
            if (dut_vec !== model_vec()) begin
                failures++;
                $display("FAIL basic_random[%0d]: got %h expected %h", i, dut_vec, model_vec());
            end
        end
    endtask

    task automatic test_overflow();
        logic [7:0]  bytes[$];
        logic [31:0] first;
        do_reset();
        for (int i = 0; i < 4 * DEPTH + 4; i++) bytes.push_back(8'($urandom));
        first = {bytes[3], bytes[2], bytes[1], bytes[0]};
        for (int i = 0; i < 4 * DEPTH + 4; i++) begin
            cycle(1'b1, bytes[i], 1'b0, 1'b0);
            checks++;
            if (dut_vec !== model_vec()) begin
                failures++;
                $display("FAIL overflow_fill[%0d]: got %h expected %h", i, dut_vec, model_vec());
            end
        end
        checks++;
        if (level !== LVL_W'(DEPTH) || overflow !== 1'b1 || out_word !== first) begin
            failures++;
            $display("FAIL overflow_state: level=%0d ovf=%b head=%h expected %0d 1 %h",
                     level, overflow, out_word, DEPTH, first);
        end
        // Clear collides with another dropped word: the set must win.
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        cycle(1'b1, 8'($urandom), 1'b0, 1'b1);
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow_set_wins: got %b expected 1", overflow);
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        checks++;
        if (overflow !== 1'b0 || dut_vec !== model_vec()) begin
            failures++;
            $display("FAIL overflow_clear: got %h expected %h", dut_vec, model_vec());
        end
    endtask

    task automatic test_full_pop_push();
        logic [7:0]  bytes[$];
        logic [31:0] second;
        do_reset();
        for (int i = 0; i < 4 * DEPTH + 4; i++) bytes.push_back(8'($urandom));
        second = {bytes[7], bytes[6], bytes[5], bytes[4]};
        for (int i = 0; i < 4 * DEPTH + 3; i++) cycle(1'b1, bytes[i], 1'b0, 1'b0);
        cycle(1'b1, bytes[4 * DEPTH + 3], 1'b1, 1'b0);
        checks++;
        if (level !== LVL_W'(DEPTH) || overflow !== 1'b0 || out_word !== second) begin
            failures++;
            $display("FAIL full_pop_push: level=%0d ovf=%b head=%h expected %0d 0 %h",
                     level, overflow, out_word, DEPTH, second);
        end
        for (int i = 0; i < DEPTH + 1; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
            checks++;
            if (dut_vec !== model_vec()) begin
                failures++;
                $display("FAIL full_drain[%0d]: got %h expected %h", i, dut_vec, model_vec());
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        cycle(1'b1, 8'hAA, 1'b0, 1'b0);
        cycle(1'b1, 8'hBB, 1'b0, 1'b0);
        for (int i = 0; i < TIMEOUT; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
        checks++;
        if (byte_idx !== (TO_EN ? 2'd0 : 2'd2) || frame_err !== TO_EN) begin
            failures++;
            $display("FAIL timeout_expire: idx=%0d ferr=%b expected %0d %b",
                     byte_idx, frame_err, TO_EN ? 0 : 2, TO_EN);
        end
        cycle(1'b1, 8'h01, 1'b0, 1'b0);
        cycle(1'b1, 8'h02, 1'b0, 1'b0);
        cycle(1'b1, 8'h03, 1'b0, 1'b0);
        cycle(1'b1, 8'h04, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_word !== (TO_EN ? 32'h04030201 : 32'h0201BBAA)) begin
            failures++;
            $display("FAIL timeout_next_word: valid=%b word=%h expected 1 %h",
                     out_valid, out_word, TO_EN ? 32'h04030201 : 32'h0201BBAA);
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        checks++;
        if (dut_vec !== model_vec()) begin
            failures++;
            $display("FAIL timeout_clear: got %h expected %h", dut_vec, model_vec());
        end
        // A byte on the would-be expiry cycle is accepted and raises no error.
        do_reset();
        cycle(1'b1, 8'hCC, 1'b0, 1'b0);
        for (int i = 0; i < TIMEOUT - 1; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b1, 8'hDD, 1'b0, 1'b0);
        checks++;
        if (byte_idx !== 2'd2 || frame_err !== 1'b0 || dut_vec !== model_vec()) begin
            failures++;
            $display("FAIL timeout_race: idx=%0d ferr=%b expected 2 0", byte_idx, frame_err);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  bytes[$];
        logic [31:0] sent[$];
        logic [31:0] got[$];
        int          k;
        int          c;
        bit          ordy;
        bit          rdy;
        do_reset();
        for (int w = 0; w < 3 * DEPTH; w++) begin
            logic [31:0] word;
            word = $urandom;
            sent.push_back(word);
            for (int j = 0; j < 4; j++) bytes.push_back(word[8*j +: 8]);
        end
        k = 0;
        c = 0;
        while ((k < bytes.size() || mq.size() != 0) && c < 2000) begin
            ordy = (c % 2) == 0;
            rdy  = (k < bytes.size()) && ($urandom_range(0, 3) != 0);
            if (out_valid === 1'b1 && ordy) got.push_back(out_word);
            cycle(rdy, rdy ? bytes[k] : 8'h00, ordy, 1'b0);
            if (rdy) k++;
            c++;
            checks++;
            if (dut_vec !== model_vec()) begin
                failures++;
                $display("FAIL stream_cycle[%0d]: got %h expected %h", c, dut_vec, model_vec());
            end
        end
        checks++;
        if (c >= 2000) begin
            failures++;
            $display("FAIL stream_timeout: cycle budget exhausted after %0d cycles", c);
        end
        checks++;
        if (got.size() != sent.size()) begin
            failures++;
            $display("FAIL stream_count: got %0d words expected %0d", got.size(), sent.size());
        end else begin
            for (int i = 0; i < sent.size(); i++) begin
                checks++;
                if (got[i] !== sent[i]) begin
                    failures++;
                    $display("FAIL stream_order[%0d]: got %h expected %h", i, got[i], sent[i]);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        checks++;
        if (level !== LVL_W'(2) || byte_idx !== 2'd2) begin
            failures++;
            $display("FAIL midreset_setup: level=%0d idx=%0d expected 2 2", level, byte_idx);
        end
        #2;
        res_n = 1'b0;
        #1;
        checks++;
        if (dut_vec !== '0) begin
            failures++;
            $display("FAIL midreset_async: got %h expected all zero", dut_vec);
        end
        model_clear();
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_hold: valid=%b expected 0", out_valid);
        end
        res_n = 1'b1;
        cycle(1'b1, 8'h5A, 1'b0, 1'b0);
        cycle(1'b1, 8'h6B, 1'b0, 1'b0);
        cycle(1'b1, 8'h7C, 1'b0, 1'b0);
        cycle(1'b1, 8'h8D, 1'b0, 1'b0);
        checks++;
        if (out_word !== 32'h8D7C6B5A || level !== LVL_W'(1) || dut_vec !== model_vec()) begin
            failures++;
            $display("FAIL midreset_clean_word: word=%h level=%0d expected 8d7c6b5a 1", out_word, level);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_pop_push();
        test_timeout();
        test_back_to_back();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
